// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO of FIFO_DEPTH bytes feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN to add an even-parity bit between DATA and STOP.
`timescale 1ns/1ps
module uart_tx_buf #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic [2:0] baud_set,
    output logic       full,
    output logic       empty,
    output logic       rs232_tx,
    output logic       tx_done,
    output logic       uart_state
);
    localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_nxt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [12:0]   baud_cnt, div;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          push, pop, bit_end, tx_nxt;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    function automatic logic [12:0] div_sel(input logic [2:0] sel);
        case (sel)
            3'd1:    return 13'd2604;
            3'd2:    return 13'd1302;
            3'd3:    return 13'd868;
            3'd4:    return 13'd434;
            default: return 13'd5208;
        endcase
    endfunction

    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign push       = wr_en && !full;
    assign bit_end    = (baud_cnt == div - 13'd1);
    assign uart_state = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pop happens either from IDLE or on the final STOP clock, so frames chain with no gap.
    always_comb begin
        state_nxt = state;
        tx_nxt    = rs232_tx;
        pop       = 1'b0;
        tx_done   = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end
            end
            START: if (bit_end) begin
                state_nxt = DATA;
                tx_nxt    = shreg[0];
            end
            DATA: if (bit_end) begin
                if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = PARITY;
                    tx_nxt    = par;
`else
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
`endif
                end else begin
                    tx_nxt = shreg[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
                state_nxt = STOP;
                tx_nxt    = 1'b1;
            end
`endif
            STOP: if (bit_end) begin
                tx_done = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    tx_nxt    = 1'b0;
                    state_nxt = START;
                end else begin
                    tx_nxt    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rs232_tx <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            baud_cnt <= '0;
            div      <= 13'd5208;
            bit_idx  <= '0;
            shreg    <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            rs232_tx <= tx_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Rate is captured with the byte so a mid-frame baud_set change waits for the next frame.
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                shreg  <= mem[rd_ptr];
                div    <= div_sel(baud_set);
`ifdef UART_TX_PARITY_EN
                par    <= ^mem[rd_ptr];
`endif
            end else if (state == DATA && bit_end) begin
                shreg <= shreg >> 1;
            end
            if (state == IDLE || bit_end) baud_cnt <= '0;
            else                          baud_cnt <= baud_cnt + 1'b1;
            if (state == DATA && bit_end) bit_idx <= bit_idx + 1'b1;
        end
    end
endmodule
